// File: rtl/seq_bit_serializer_if.sv
// Parallel-word handshake plus serial output bundle for seq_bit_serializer.
// The master side supplies words; the slave side (the serializer) emits the bit stream.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, last, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter feeding a downstream sequence detector.
// Emits one registered bit per cycle, with optional idle gap cycles after each word.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int GAP       = 0
) (
  input logic                 clk,
  input logic                 rst,
  seq_bit_serializer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gapCnt_q, gapCnt_d;
  logic             x_q, x_d;
  logic             xValid_q, xValid_d;
  logic             last_q, last_d;
  logic             ready;
  logic             transfer;

  function automatic logic headBit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] dropHead(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready is also open during the last bit when there is no gap, so words stream back-to-back.
  assign ready    = rst && ((state_q == ST_IDLE) ||
                            ((state_q == ST_SHIFT) && last_q && (GAP == 0)));
  assign transfer = bus.din_valid && ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      gapCnt_q <= '0;
      x_q      <= IDLE_BIT;
      xValid_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      gapCnt_q <= gapCnt_d;
      x_q      <= x_d;
      xValid_q <= xValid_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    gapCnt_d = gapCnt_q;
    x_d      = IDLE_BIT;
    xValid_d = 1'b0;
    last_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d  = ST_SHIFT;
          x_d      = headBit(bus.din);
          shift_d  = dropHead(bus.din);
          cnt_d    = '0;
          xValid_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!last_q) begin
          x_d      = headBit(shift_q);
          shift_d  = dropHead(shift_q);
          cnt_d    = cnt_q + CW'(1);
          xValid_d = 1'b1;
          last_d   = (cnt_q == CW'(WIDTH - 2));
        end else if (transfer) begin
          x_d      = headBit(bus.din);
          shift_d  = dropHead(bus.din);
          cnt_d    = '0;
          xValid_d = 1'b1;
        end else if (GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_GAP;
          gapCnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gapCnt_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gapCnt_d = gapCnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.din_ready = ready;
  assign bus.x         = x_q;
  assign bus.x_valid   = xValid_q;
  assign bus.last      = last_q;
  assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_GAP);
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: two instances (MSB-first/no gap, LSB-first/gap 2)
// driven by directed words then random traffic, checked against a cycle-stamped bit model.
module tb_seq_bit_serializer;
  localparam int W      = 8;
  localparam int GAP_A  = 0;
  localparam int GAP_B  = 2;
  localparam bit MSB_A  = 1'b1;
  localparam bit MSB_B  = 1'b0;
  localparam bit IDLE_A = 1'b0;
  localparam bit IDLE_B = 1'b1;

  typedef struct {
    int cyc;
    bit b;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t         expQ [2][$];
  logic [W-1:0] pend [2][$];
  int           lastCycle [2];
  int           readyFrom [2];
  bit           acc [2];
  logic         xv [2];
  logic         xs [2];
  logic         ls [2];
  logic         rdy [2];
  logic         bsy [2];

  seq_bit_serializer_if #(.WIDTH(W)) busA ();
  seq_bit_serializer_if #(.WIDTH(W)) busB ();

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(MSB_A), .IDLE_BIT(IDLE_A), .GAP(GAP_A)) dutA (
    .clk(clk), .rst(rst), .bus(busA)
  );
  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(MSB_B), .IDLE_BIT(IDLE_B), .GAP(GAP_B)) dutB (
    .clk(clk), .rst(rst), .bus(busB)
  );

  assign xv[0]  = busA.x_valid;
  assign xs[0]  = busA.x;
  assign ls[0]  = busA.last;
  assign rdy[0] = busA.din_ready;
  assign bsy[0] = busA.busy;
  assign xv[1]  = busB.x_valid;
  assign xs[1]  = busB.x;
  assign ls[1]  = busB.last;
  assign rdy[1] = busB.din_ready;
  assign bsy[1] = busB.busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gapOf(input int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic bit msbOf(input int i);
    return (i == 0) ? MSB_A : MSB_B;
  endfunction

  function automatic bit idleOf(input int i);
    return (i == 0) ? IDLE_A : IDLE_B;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %0h want %0h", name, i, cyc, got, want);
    end
  endtask

  task automatic flagMissed(input int i, input int wantCyc);
    checks++;
    errors++;
    $display("[TB] FAIL missed_bit dut%0d cycle %0d: got no bit, want bit due in cycle %0d", i, cyc, wantCyc);
  endtask

  // Ready/busy follow from word timing: ready from the last bit (no gap) or after the gap.
  task automatic checkOutput(input int i, input bit rstN, input bit v, input logic [W-1:0] d);
    int  c;
    bit  expReady;
    bit  expBusy;
    c        = cyc;
    expReady = rstN && (c >= readyFrom[i]);
    expBusy  = (c <= lastCycle[i] + gapOf(i));
    check("din_ready", i, {31'b0, rdy[i]}, {31'b0, expReady});
    check("busy", i, {31'b0, bsy[i]}, {31'b0, expBusy});
    acc[i] = 1'b0;
    if (!rstN) begin
      while (expQ[i].size() > 0 && expQ[i][$].cyc > c) void'(expQ[i].pop_back());
      lastCycle[i] = -100;
      readyFrom[i] = -100;
    end else if (v && expReady) begin
      acc[i] = 1'b1;
      for (int j = 0; j < W; j++) begin
        exp_t e;
        e.cyc  = c + 1 + j;
        e.b    = msbOf(i) ? d[W-1-j] : d[j];
        e.last = (j == W - 1);
        expQ[i].push_back(e);
      end
      lastCycle[i] = c + W;
      readyFrom[i] = (gapOf(i) == 0) ? c + W : c + W + gapOf(i) + 1;
    end
  endtask

  task automatic applyStimulus(input bit rstN, input bit v0, input logic [W-1:0] d0,
                               input bit v1, input logic [W-1:0] d1);
    @(negedge clk);
    rst            = rstN;
    busA.din       = d0;
    busA.din_valid = v0;
    busB.din       = d1;
    busB.din_valid = v1;
    #1;
    checkOutput(0, rstN, v0, d0);
    checkOutput(1, rstN, v1, d1);
  endtask

  task automatic runCycles(input int n, input bit rstN, input bit randMode);
    bit           v [2];
    logic [W-1:0] d [2];
    bit           r;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) begin
        d[i] = W'($urandom);
        if (pend[i].size() > 0) begin
          v[i] = 1'b1;
          d[i] = pend[i][0];
        end else begin
          v[i] = randMode ? ($urandom_range(0, 9) < 6) : 1'b0;
        end
      end
      r = rstN;
      if (randMode && $urandom_range(0, 99) == 0) r = 1'b0;
      applyStimulus(r, v[0], d[0], v[1], d[1]);
      for (int i = 0; i < 2; i++) begin
        if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      end
    end
  endtask

  // Monitor: every cycle each output either carries the next scheduled bit or idles.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit   expV;
        exp_t e;
        while (expQ[i].size() > 0 && expQ[i][0].cyc < cyc) begin
          flagMissed(i, expQ[i][0].cyc);
          void'(expQ[i].pop_front());
        end
        expV = (expQ[i].size() > 0) && (expQ[i][0].cyc == cyc);
        check("x_valid", i, {31'b0, xv[i]}, {31'b0, expV});
        if (expV) begin
          e = expQ[i].pop_front();
          check("x", i, {31'b0, xs[i]}, {31'b0, e.b});
          check("last", i, {31'b0, ls[i]}, {31'b0, e.last});
        end else begin
          check("x_idle", i, {31'b0, xs[i]}, {31'b0, idleOf(i)});
          check("last_idle", i, {31'b0, ls[i]}, 32'd0);
        end
      end
    end
  end

  initial begin
    busA.din       = '0;
    busA.din_valid = 1'b0;
    busB.din       = '0;
    busB.din_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lastCycle[i] = -100;
      readyFrom[i] = -100;
      acc[i]       = 1'b0;
    end

    runCycles(2, 1'b0, 1'b0);

    pend[0].push_back(8'h5A);
    pend[1].push_back(8'h01);
    runCycles(12, 1'b1, 1'b0);

    pend[0].push_back(8'hA5);
    pend[0].push_back(8'h3C);
    pend[1].push_back(8'hC3);
    runCycles(22, 1'b1, 1'b0);

    // Abort a word after three bits, then send a fresh word.
    pend[0].push_back(8'hFF);
    pend[1].push_back(8'hFF);
    runCycles(3, 1'b1, 1'b0);
    runCycles(1, 1'b0, 1'b0);
    pend[0].push_back(8'h80);
    pend[1].push_back(8'h80);
    runCycles(12, 1'b1, 1'b0);

    runCycles(400, 1'b1, 1'b1);
    runCycles(20, 1'b1, 1'b0);

    for (int i = 0; i < 2; i++) check("queue_drained", i, expQ[i].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_bit_serializer.md
SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001: Parameter WIDTH, default 8, is the parallel word width in bits (legal range 2..32).
REQ-002: Parameter MSB_FIRST, default 1; 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003: Parameter IDLE_BIT, default 0, is the value driven on x whenever x_valid=0.
REQ-004: Parameter GAP, default 0, is the number of idle cycles inserted after each word (legal range 0..15).
REQ-005: clk  input  1  single clock; all state updates on its rising edge.
REQ-006: rst  input  1  reset, synchronous, active-low (rst=0 sampled at a clk rising edge resets the block).
REQ-007: din  input  WIDTH  parallel word to serialize.
REQ-008: din_valid  input  1  din holds a word to send.
REQ-009: din_ready  output  1  block accepts din this cycle; a transfer occurs when din_valid=1 and din_ready=1 at a rising edge.
REQ-010: x  output  1  serial bit stream, registered, for the downstream sequence-detector stage.
REQ-011: x_valid  output  1  x carries a data bit this cycle, registered.
REQ-012: last  output  1  x carries the final bit of the current word, registered.
REQ-013: busy  output  1  state is SHIFT or GAP.

Function
REQ-014: The state machine SHALL have exactly three states: IDLE, SHIFT, GAP.
REQ-015: IDLE: din_ready=1, x_valid=0, x=IDLE_BIT; a transfer moves the state to SHIFT and captures din into the shift register.
REQ-016: For a transfer at edge k, x_valid SHALL be 1 for cycles k+1 through k+WIDTH, with x equal to successive word bits in the order MSB_FIRST selects.
REQ-017: last SHALL be 1 only in cycle k+WIDTH.
REQ-018: The bit counter SHALL count 0..WIDTH-1 and reload to 0 on every transfer, with no wrap past WIDTH-1.
REQ-019: din_ready SHALL be combinational: 1 in IDLE, or in SHIFT when last=1 and GAP=0; 0 otherwise.
REQ-020: Back-to-back, GAP=0: a transfer while last=1 SHALL put the new word's first bit on x in the next cycle, with no x_valid bubble.
REQ-021: In SHIFT with last=1 and no transfer: if GAP=0 the next state SHALL be IDLE; if GAP>0 it SHALL be GAP.
REQ-022: GAP SHALL last exactly GAP cycles, with x_valid=0, x=IDLE_BIT, last=0 and din_ready=0, then return to IDLE.
REQ-023: When din_ready=0, din and din_valid SHALL be ignored.
REQ-024: Changes on din after a transfer SHALL NOT affect the bits being shifted.
REQ-025: busy SHALL be 1 in SHIFT and GAP and 0 in IDLE.
REQ-026: Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027: At a rising edge with rst=0, the block SHALL set state=IDLE, shift register=0, bit counter=0, gap counter=0, x=IDLE_BIT, x_valid=0, last=0 and busy=0.
REQ-028: din_ready SHALL be 0 while rst=0 and 1 in the first cycle after rst returns high.
REQ-029: Reset mid-word or mid-gap SHALL discard all remaining bits and cycles, with no completion of the word.
REQ-030: The first transfer after reset SHALL start from bit 0 of the counter.

Verification
REQ-031: WIDTH=8, MSB_FIRST=1, GAP=0, din=8'b0101_1010 accepted at edge 0 -> x=0,1,0,1,1,0,1,0 in cycles 1..8; last=1 only in cycle 8; x_valid=0 in cycle 9.
REQ-032: Back-to-back, din_valid held high, din=8'hA5 then 8'h3C -> 16 contiguous x_valid cycles carrying 1010_0101 then 0011_1100; din_ready=1 in cycle 8.
REQ-033: GAP=2, one word -> after last, 2 cycles with x_valid=0, din_ready=0, busy=1; din_ready=1 in the 3rd cycle.
REQ-034: MSB_FIRST=0, din=8'h01 -> x=1 in cycle 1, then 0 in cycles 2..8.
REQ-035: rst=0 for one edge after 3 bits of 8'hFF -> next cycle x_valid=0, x=IDLE_BIT, busy=0; a new word 8'h80 after release emits 1 followed by seven 0s.
REQ-036: din_valid=1 with a changing din during SHIFT and GAP -> no transfer and the output stream is unchanged; din_valid=0 in IDLE -> x_valid stays 0.
